reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised successor to the single-output power-on reset generator.
//  Holds NUM_CH downstream reset domains (LCD, chip core, UART, ...) in reset
//  after power-up, then releases them one by one in index order at fixed spacing.
//  Re-enters the sequence on a debounced external button request or a soft request pulse.
//  Records the cause of the last sequence. Sits directly under top, driving each domain's reset.
// PARAMETERS
//  NUM_CH        3          number of reset domains released in sequence (>=1)
//  CNT_W         21         width of the shared delay counter
//  POR_CYCLES    21'h17D796 initial hold after reset / request (0.062 s @ 25 MHz); < 2**CNT_W
//  STAGE_CYCLES  1024       spacing between consecutive channel releases (>=1); < 2**CNT_W
//  FILTER_CYCLES 16         consecutive synchronised-high samples needed to accept btn_reset (>=1)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high; restarts the whole sequence
//  btn_reset  in   1        raw, asynchronous, active-high external reset request
//  soft_req   in   1        single-cycle active-high software reset request (clk domain)
//  run        out  NUM_CH   run[k]=1: domain k released (active-high "user_reset" sense)
//  done       out  1        1 when every channel is released
//  cause      out  2        2'b00 power-on/reset, 2'b01 button, 2'b10 soft; 2'b11 unused
// BEHAVIOUR
//  Reset (reset=1 at a clk edge): run=0, done=0, cause=2'b00, state=HOLD,
//   counter=POR_CYCLES, synchroniser flops=0, filter count=0, stage index=0.
//  btn_reset: 2-flop synchroniser, then filter counter; accepted request (ext_req) is
//   high while the synchronised input has been high for >=FILTER_CYCLES consecutive
//   cycles; any low sample clears the filter count and ext_req in the next cycle.
//  States:
//   HOLD:  run all 0. ext_req=1 -> counter reloads POR_CYCLES (held indefinitely).
//          Else counter!=0 -> decrement; counter==0 -> run[0]<=1, stage=1,
//          counter<=STAGE_CYCLES-1, go STAGE (or RUN with done<=1 if NUM_CH==1).
//   STAGE: counter!=0 -> decrement; counter==0 -> run[stage]<=1, stage++, counter reload;
//          when run[NUM_CH-1] is set, done<=1 in the same edge, go RUN.
//   RUN:   all run=1, done=1; counter idle.
//  Timing: with no requests, run[0] rises exactly POR_CYCLES+1 edges after the first
//   edge with reset=0; run[k] rises exactly STAGE_CYCLES edges after run[k-1]; done
//   rises on the same edge as run[NUM_CH-1]. Released channels never drop except by request.
//  Requests (from STAGE or RUN, and ext_req also in HOLD as above): on the edge where
//   ext_req=1 or soft_req=1 is sampled, run<=0, done<=0, stage<=0, counter<=POR_CYCLES,
//   state<=HOLD, cause updated. soft_req while already in HOLD restarts counter, sets cause.
//  Simultaneous ext_req and soft_req: button wins, cause=2'b01.
//  reset overrides all requests in the same cycle; cause=2'b00.
//  Counter arithmetic is CNT_W-bit unsigned, never wraps (decrement only when !=0).
// TESTING  (bench params: NUM_CH=3, POR_CYCLES=10, STAGE_CYCLES=4, FILTER_CYCLES=3)
//  Release sequence: reset 1 for 2 cycles then 0 -> run 3'b001 at edge 11, 3'b011 at 15,
//   3'b111 + done=1 at 19; cause=2'b00 throughout.
//  Soft request: in RUN pulse soft_req 1 cycle -> run=0, done=0 next edge, cause=2'b10;
//   run[0] returns 11 edges later, full sequence repeats.
//  Button filter: btn_reset high 2 cycles then low -> no effect; high 8 cycles ->
//   run drops 5 edges after rising (2 sync + 3 filter), cause=2'b01; held until release,
//   run[0] rises 11 edges after ext_req falls.
//  Simultaneous: soft_req and accepted ext_req same cycle -> cause=2'b01.
//  Reset mid-STAGE (run=3'b011): reset 1 cycle -> run=0, cause=2'b00, timing as first test.
//  NUM_CH=1 build: run[0] and done rise together at edge 11.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// reset_sequencer_if
//   Groups the request inputs and the per-domain reset outputs of the
//   reset sequencer.
//
//   Signals
//     btn_reset  raw asynchronous active-high external reset request
//     soft_req   single-cycle active-high software reset request (clk domain)
//     run        run[k]=1: reset domain k released
//     done       1 once every domain is released
//     cause      cause of the last sequence: 00 reset, 01 button, 10 soft
//
//   Request semantics: there is no ready/acknowledge. soft_req is a plain
//   one-cycle strobe that is always taken on the edge that samples it.
//   btn_reset is a level that is only acted on after synchronisation and
//   filtering. run, done and cause are registered and change only on
//   the rising edge of clk.
//
//   Modports
//     master  drives the requests, observes the reset outputs
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int NUM_CH = 3
);
    logic              btn_reset;
    logic              soft_req;
    logic [NUM_CH-1:0] run;
    logic              done;
    logic [1:0]        cause;

    modport master (
        output btn_reset,
        output soft_req,
        input  run,
        input  done,
        input  cause
    );

    modport slave (
        input  btn_reset,
        input  soft_req,
        output run,
        output done,
        output cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Holds NUM_CH reset domains in reset after power-up, then releases them
//   one at a time in index order, STAGE_CYCLES apart. A debounced button
//   request or a soft request pulse restarts the whole sequence. The cause
//   of the most recent sequence is recorded.
//
//   Ports
//     clk          system clock
//     reset        synchronous active-high reset; restarts the sequence
//     bus          reset_sequencer_if.slave: btn_reset, soft_req in;
//                  run, done, cause out
//     dbg_state_o  current FSM state (0 HOLD, 1 STAGE, 2 RUN)
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int          NUM_CH        = 3,
    parameter int          CNT_W         = 21,
    parameter int unsigned POR_CYCLES    = 21'h17D796,
    parameter int unsigned STAGE_CYCLES  = 1024,
    parameter int unsigned FILTER_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    reset_sequencer_if.slave        bus,
    output logic [1:0]              dbg_state_o
);

    localparam int STG_W  = (NUM_CH > 1) ? $clog2(NUM_CH + 1) : 1;
    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

    localparam logic [CNT_W-1:0]  POR_LD   = CNT_W'(POR_CYCLES);
    localparam logic [CNT_W-1:0]  STAGE_LD = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [STG_W-1:0]  LAST_CH  = STG_W'(NUM_CH - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STG_W-1:0]    stage_q, stage_d;
    logic [NUM_CH-1:0]   run_q, run_d;
    logic                done_q, done_d;
    logic [1:0]          cause_q, cause_d;
    logic                sync1_q, sync2_q;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic                ext_req;

    // The filter count saturates at FILTER_CYCLES-1 so that, together with
    // the current high sample, ext_req asserts on the FILTER_CYCLES-th
    // consecutive synchronised-high cycle. A low sample drops ext_req at once.
    assign ext_req = sync2_q && (filt_q >= FILT_MAX);

    always_comb begin
        filt_d = filt_q;
        if (!sync2_q) begin
            filt_d = '0;
        end else if (filt_q < FILT_MAX) begin
            filt_d = filt_q + FILT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        run_d   = run_q;
        done_d  = done_q;
        cause_d = cause_q;

        case (state_q)
            HOLD: begin
                if (ext_req) begin
                    cnt_d   = POR_LD;
                    cause_d = CAUSE_BTN;
                end else if (bus.soft_req) begin
                    cnt_d   = POR_LD;
                    cause_d = CAUSE_SOFT;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    run_d[0] = 1'b1;
                    if (NUM_CH == 1) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        stage_d = STG_W'(1);
                        cnt_d   = STAGE_LD;
                        state_d = STAGE;
                    end
                end
            end

            STAGE, RUN: begin
                if (ext_req || bus.soft_req) begin
                    run_d   = '0;
                    done_d  = 1'b0;
                    stage_d = '0;
                    cnt_d   = POR_LD;
                    state_d = HOLD;
                    cause_d = ext_req ? CAUSE_BTN : CAUSE_SOFT;
                end else if (state_q == STAGE) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (STG_W'(k) == stage_q) begin
                                run_d[k] = 1'b1;
                            end
                        end
                        stage_d = stage_q + STG_W'(1);
                        cnt_d   = STAGE_LD;
                        if (stage_q == LAST_CH) begin
                            done_d  = 1'b1;
                            state_d = RUN;
                        end
                    end
                end
            end

            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HOLD;
            cnt_q   <= POR_LD;
            stage_q <= '0;
            run_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_POR;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            run_q   <= run_d;
            done_q  <= done_d;
            cause_q <= cause_d;
            sync1_q <= bus.btn_reset;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
        end
    end

    assign bus.run     = run_q;
    assign bus.done    = done_q;
    assign bus.cause   = cause_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer with NUM_CH=3, POR_CYCLES=10,
//   STAGE_CYCLES=4, FILTER_CYCLES=3, plus a NUM_CH=1 instance sharing the
//   clock and reset. Expected values are hand-derived edge counts.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;

    int n_checks = 0;
    int n_pass   = 0;

    reset_sequencer_if #(.NUM_CH(3)) bus3 ();
    reset_sequencer_if #(.NUM_CH(1)) bus1 ();

    reset_sequencer #(
        .NUM_CH(3), .CNT_W(21), .POR_CYCLES(10),
        .STAGE_CYCLES(4), .FILTER_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus3), .dbg_state_o(dbg_state)
    );

    reset_sequencer #(
        .NUM_CH(1), .CNT_W(21), .POR_CYCLES(10),
        .STAGE_CYCLES(4), .FILTER_CYCLES(3)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .dbg_state_o(dbg_state1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n active edges, then sample 1 ns later
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus3.btn_reset = 1'b0;
        bus3.soft_req  = 1'b0;
        bus1.btn_reset = 1'b0;
        bus1.soft_req  = 1'b0;

        // ---- power-on release sequence ----
        tick(2);
        check("rst_run",   32'(bus3.run),   32'h0);
        check("rst_done",  32'(bus3.done),  32'h0);
        check("rst_cause", 32'(bus3.cause), 32'h0);
        check("rst_state", 32'(dbg_state),  32'h0);
        reset = 1'b0;
        tick(10);
        check("por_e10_run",  32'(bus3.run), 32'h0);
        check("ch1_e10_run",  32'(bus1.run), 32'h0);
        tick(1);
        check("por_e11_run",  32'(bus3.run),  32'h1);
        check("por_e11_done", 32'(bus3.done), 32'h0);
        check("ch1_e11_run",  32'(bus1.run),  32'h1);
        check("ch1_e11_done", 32'(bus1.done), 32'h1);
        tick(3);
        check("por_e14_run",  32'(bus3.run), 32'h1);
        tick(1);
        check("por_e15_run",  32'(bus3.run), 32'h3);
        check("por_e15_state", 32'(dbg_state), 32'h1);
        tick(3);
        check("por_e18_run",  32'(bus3.run),  32'h3);
        check("por_e18_done", 32'(bus3.done), 32'h0);
        tick(1);
        check("por_e19_run",   32'(bus3.run),   32'h7);
        check("por_e19_done",  32'(bus3.done),  32'h1);
        check("por_e19_cause", 32'(bus3.cause), 32'h0);
        check("por_e19_state", 32'(dbg_state),  32'h2);

        // ---- soft request from RUN ----
        bus3.soft_req = 1'b1;
        tick(1);
        bus3.soft_req = 1'b0;
        check("soft_run",   32'(bus3.run),   32'h0);
        check("soft_done",  32'(bus3.done),  32'h0);
        check("soft_cause", 32'(bus3.cause), 32'h2);
        tick(10);
        check("soft_e10_run", 32'(bus3.run), 32'h0);
        tick(1);
        check("soft_e11_run", 32'(bus3.run), 32'h1);
        tick(8);
        check("soft_full_run",  32'(bus3.run),  32'h7);
        check("soft_full_done", 32'(bus3.done), 32'h1);

        // ---- short button glitch is filtered ----
        bus3.btn_reset = 1'b1;
        tick(2);
        bus3.btn_reset = 1'b0;
        tick(10);
        check("glitch_run",   32'(bus3.run),   32'h7);
        check("glitch_cause", 32'(bus3.cause), 32'h2);

        // ---- accepted button press, held 8 cycles ----
        bus3.btn_reset = 1'b1;
        tick(4);
        check("btn_e4_run", 32'(bus3.run), 32'h7);
        tick(1);
        check("btn_e5_run",   32'(bus3.run),   32'h0);
        check("btn_e5_done",  32'(bus3.done),  32'h0);
        check("btn_e5_cause", 32'(bus3.cause), 32'h1);
        check("btn_e5_state", 32'(dbg_state),  32'h0);
        tick(3);
        bus3.btn_reset = 1'b0;
        tick(12);
        check("btn_e20_run", 32'(bus3.run), 32'h0);
        tick(1);
        check("btn_e21_run", 32'(bus3.run), 32'h1);
        tick(8);
        check("btn_full_run",   32'(bus3.run),   32'h7);
        check("btn_full_cause", 32'(bus3.cause), 32'h1);

        // ---- soft request and accepted button in the same cycle ----
        bus3.soft_req = 1'b1;
        tick(1);
        bus3.soft_req = 1'b0;
        check("pre_sim_cause", 32'(bus3.cause), 32'h2);
        tick(19);
        check("pre_sim_run", 32'(bus3.run), 32'h7);
        bus3.btn_reset = 1'b1;
        tick(4);
        bus3.soft_req = 1'b1;
        tick(1);
        bus3.soft_req  = 1'b0;
        bus3.btn_reset = 1'b0;
        check("sim_cause", 32'(bus3.cause), 32'h1);
        check("sim_run",   32'(bus3.run),   32'h0);
        tick(12);
        check("sim_e17_run", 32'(bus3.run), 32'h0);
        tick(1);
        check("sim_e18_run", 32'(bus3.run), 32'h1);
        tick(4);
        check("sim_e22_run",   32'(bus3.run), 32'h3);
        check("sim_e22_state", 32'(dbg_state), 32'h1);

        // ---- reset in the middle of STAGE ----
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_run",   32'(bus3.run),   32'h0);
        check("mid_done",  32'(bus3.done),  32'h0);
        check("mid_cause", 32'(bus3.cause), 32'h0);
        tick(10);
        check("mid_e10_run", 32'(bus3.run), 32'h0);
        check("mid_ch1_e10", 32'(bus1.run), 32'h0);
        tick(1);
        check("mid_e11_run", 32'(bus3.run), 32'h1);
        check("mid_ch1_e11", 32'(bus1.done), 32'h1);
        tick(4);
        check("mid_e15_run", 32'(bus3.run), 32'h3);
        tick(4);
        check("mid_e19_run",  32'(bus3.run),  32'h7);
        check("mid_e19_done", 32'(bus3.done), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
